// File: rtl/hps_reset_sequencer.sv
// Staged fabric reset release gated by synchronised HPS reset and PLL lock, plus stretched f2h reset requests.
// Domain i releases LOCK_DEBOUNCE+(i+1)*STAGGER_CYCLES+1 cycles after good; request pulses start the cycle after the request.
module hps_reset_sequencer #(
    parameter int NUM_DOMAINS      = 4,
    parameter int STAGGER_CYCLES   = 16,
    parameter int LOCK_DEBOUNCE    = 32,
    parameter int SYNC_STAGES      = 2,
    parameter int REQ_PULSE_CYCLES = 8,
    parameter int CNT_W            = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   h2f_reset_n_i,
    input  logic                   pll_locked_i,
    input  logic                   cold_req_i,
    input  logic                   warm_req_i,
    input  logic                   debug_req_i,
    output logic [NUM_DOMAINS-1:0] domain_rst_n_o,
    output logic                   all_released_o,
    output logic                   f2h_cold_reset_req_n_o,
    output logic                   f2h_warm_reset_req_n_o,
    output logic                   f2h_debug_reset_req_n_o,
    output logic [1:0]             seq_state_o
);

    typedef enum logic [1:0] {
        S_HOLD     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_RELEASE  = 2'd2,
        S_RUN      = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_PULSE = 2'd1,
        R_GAP   = 2'd2
    } req_state_t;

    localparam int PW = (REQ_PULSE_CYCLES > 1) ? $clog2(REQ_PULSE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(LOCK_DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(NUM_DOMAINS * STAGGER_CYCLES - 1);
    localparam logic [PW-1:0]    PLS_LAST = PW'(REQ_PULSE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] h2f_sync_q;
    logic [SYNC_STAGES-1:0] pll_sync_q;
    logic                   good_d;

    seq_state_t             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [NUM_DOMAINS-1:0] dom_q;
    logic                   all_rel_q;

    req_state_t             rq_state_q;
    logic [PW-1:0]          pcnt_q;
    logic                   cold_n_q;
    logic                   warm_n_q;
    logic                   dbg_n_q;
    logic                   force_hold_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            h2f_sync_q <= '0;
            pll_sync_q <= '0;
        end else begin
            h2f_sync_q <= {h2f_sync_q[SYNC_STAGES-2:0], h2f_reset_n_i};
            pll_sync_q <= {pll_sync_q[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    assign good_d = h2f_sync_q[SYNC_STAGES-1] & pll_sync_q[SYNC_STAGES-1];

    // Cold/warm pulses reset the fabric too: the HPS is about to go down under it.
    assign force_hold_d = (rq_state_q == R_IDLE) && (cold_req_i || warm_req_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            dom_q     <= '0;
            all_rel_q <= 1'b0;
        end else if (force_hold_d || (!good_d && state_q != S_HOLD)) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            dom_q     <= '0;
            all_rel_q <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    cnt_q     <= '0;
                    dom_q     <= '0;
                    all_rel_q <= 1'b0;
                    if (good_d) begin
                        state_q <= S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (cnt_q == DEB_LAST) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (cnt_q == CNT_W'((i + 1) * STAGGER_CYCLES - 1)) begin
                            dom_q[i] <= 1'b1;
                        end
                    end
                    if (cnt_q == REL_LAST) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    all_rel_q <= 1'b1;
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    // Lower-priority simultaneous requests are dropped, never queued.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rq_state_q <= R_IDLE;
            pcnt_q     <= '0;
            cold_n_q   <= 1'b1;
            warm_n_q   <= 1'b1;
            dbg_n_q    <= 1'b1;
        end else begin
            case (rq_state_q)
                R_IDLE: begin
                    pcnt_q <= '0;
                    if (cold_req_i) begin
                        cold_n_q   <= 1'b0;
                        rq_state_q <= R_PULSE;
                    end else if (warm_req_i) begin
                        warm_n_q   <= 1'b0;
                        rq_state_q <= R_PULSE;
                    end else if (debug_req_i) begin
                        dbg_n_q    <= 1'b0;
                        rq_state_q <= R_PULSE;
                    end
                end
                R_PULSE: begin
                    if (pcnt_q == PLS_LAST) begin
                        cold_n_q   <= 1'b1;
                        warm_n_q   <= 1'b1;
                        dbg_n_q    <= 1'b1;
                        rq_state_q <= R_GAP;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                R_GAP: begin
                    rq_state_q <= R_IDLE;
                end
                default: begin
                    rq_state_q <= R_IDLE;
                    cold_n_q   <= 1'b1;
                    warm_n_q   <= 1'b1;
                    dbg_n_q    <= 1'b1;
                end
            endcase
        end
    end

    assign domain_rst_n_o          = dom_q;
    assign all_released_o          = all_rel_q;
    assign f2h_cold_reset_req_n_o  = cold_n_q;
    assign f2h_warm_reset_req_n_o  = warm_n_q;
    assign f2h_debug_reset_req_n_o = dbg_n_q;
    assign seq_state_o             = state_q;

endmodule
